// File: rtl/id_ex_operand_stage_if.sv
// ID/EX link bundle: decoded instruction from ID into the operand stage and the
// registered operand bundle from the operand stage out to EX.
interface id_ex_operand_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 16
);
  logic                  id_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_rs1;
  logic [ADDR_WIDTH-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [ADDR_WIDTH-1:0] id_rd;
  logic                  id_wb_en;
  logic                  id_is_load;
  logic [CTRL_WIDTH-1:0] id_ctrl;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [DATA_WIDTH-1:0] ex_op1;
  logic [DATA_WIDTH-1:0] ex_op2;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic                  ex_wb_en;
  logic                  ex_is_load;
  logic [CTRL_WIDTH-1:0] ex_ctrl;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wb_en, id_is_load, id_ctrl,
    input  id_ready,
    input  ex_valid, ex_pc, ex_op1, ex_op2, ex_rd, ex_wb_en, ex_is_load, ex_ctrl,
    output ex_ready
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wb_en, id_is_load, id_ctrl,
    output id_ready,
    output ex_valid, ex_pc, ex_op1, ex_op2, ex_rd, ex_wb_en, ex_is_load, ex_ctrl,
    input  ex_ready
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage: register-file addressing, EX/MEM forwarding,
// load-use bubble insertion and the valid/ready ID/EX pipeline register.
module id_ex_operand_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  id_ex_operand_stage_if.slave  bus,
  output logic [ADDR_WIDTH-1:0] ra0,
  output logic [ADDR_WIDTH-1:0] ra1,
  input  logic [DATA_WIDTH-1:0] rd0,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic                  exs_valid,
  input  logic [ADDR_WIDTH-1:0] exs_rd,
  input  logic                  exs_wb_en,
  input  logic                  exs_is_load,
  input  logic [DATA_WIDTH-1:0] exs_result,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic                  mem_wb_en,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wb_en_q;
  logic                  is_load_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  exs_fwd_ok;
  logic                  mem_fwd_ok;
  logic                  exs_load_pending;
  logic                  hazard;
  logic                  slot_free;
  logic                  take;

  assign ra0 = bus.id_rs1;
  assign ra1 = bus.id_rs2;

  // A load in EX has no data yet, so only ALU results are forwarded from EX.
  assign exs_fwd_ok       = exs_valid & exs_wb_en & ~exs_is_load;
  assign mem_fwd_ok       = mem_valid & mem_wb_en;
  assign exs_load_pending = exs_valid & exs_wb_en & exs_is_load & (exs_rd != '0);

  assign hazard = bus.id_valid & exs_load_pending &
                  ((bus.id_use_rs1 & (bus.id_rs1 == exs_rd)) |
                   (bus.id_use_rs2 & (bus.id_rs2 == exs_rd)));

  assign slot_free    = ~valid_q | bus.ex_ready;
  assign bus.id_ready = slot_free & ~hazard & ~flush;
  assign take         = slot_free & bus.id_valid & ~hazard & ~flush;

  // Operand select: x0 is hard zero, then the youngest producer (EX) before MEM, then the register file.
  always_comb begin
    op1 = rd0;
    op2 = rd1;
    if (bus.id_rs1 == '0)
      op1 = '0;
    else if (exs_fwd_ok && (exs_rd == bus.id_rs1))
      op1 = exs_result;
    else if (mem_fwd_ok && (mem_rd == bus.id_rs1))
      op1 = mem_result;
    if (bus.id_rs2 == '0)
      op2 = '0;
    else if (exs_fwd_ok && (exs_rd == bus.id_rs2))
      op2 = exs_result;
    else if (mem_fwd_ok && (mem_rd == bus.id_rs2))
      op2 = mem_result;
  end

  // Output valid: flush kills, otherwise refill whenever the slot drains (bubble on hazard).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      valid_q <= 1'b0;
    else if (flush)
      valid_q <= 1'b0;
    else if (slot_free)
      valid_q <= bus.id_valid & ~hazard;
  end

  // Payload capture only when an instruction is actually accepted; held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      is_load_q <= 1'b0;
      ctrl_q    <= '0;
    end else if (take) begin
      pc_q      <= bus.id_pc;
      op1_q     <= op1;
      op2_q     <= op2;
      rd_q      <= bus.id_rd;
      wb_en_q   <= bus.id_wb_en;
      is_load_q <= bus.id_is_load;
      ctrl_q    <= bus.id_ctrl;
    end
  end

  // Count cycles in which a load-use bubble is inserted, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= '0;
    else if (hazard && slot_free && !flush && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_op1     = op1_q;
  assign bus.ex_op2     = op2_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_wb_en   = wb_en_q;
  assign bus.ex_is_load = is_load_q;
  assign bus.ex_ctrl    = ctrl_q;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: vector table, directed corner
// sequences and a randomized run against a behavioural operand/pipeline model.
module tb_id_ex_operand_stage;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int NW = 16;

  logic          clk;
  logic          rstn;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;
  logic          exs_valid, exs_wb_en, exs_is_load;
  logic [AW-1:0] exs_rd;
  logic [DW-1:0] exs_result;
  logic          mem_valid, mem_wb_en;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_result;
  logic          flush, cnt_clr;
  logic [NW-1:0] stall_cnt;

  int checks = 0;
  int passes = 0;

  id_ex_operand_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  id_ex_operand_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .exs_valid(exs_valid), .exs_rd(exs_rd), .exs_wb_en(exs_wb_en),
    .exs_is_load(exs_is_load), .exs_result(exs_result),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_result(mem_result),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rs1, rs2;
    logic          use1, use2;
    logic          exs_v, exs_wb, exs_ld;
    logic [AW-1:0] exs_rd;
    logic [DW-1:0] exs_res;
    logic          mem_v, mem_wb;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_res;
    logic [DW-1:0] rf0, rf1;
    logic          exp_ready, exp_valid;
    logic [DW-1:0] exp_op1, exp_op2;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clearInputs();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = '0; bus.id_wb_en = 0;
    bus.id_is_load = 0; bus.id_ctrl = '0; bus.ex_ready = 1;
    rd0 = '0; rd1 = '0;
    exs_valid = 0; exs_rd = '0; exs_wb_en = 0; exs_is_load = 0; exs_result = '0;
    mem_valid = 0; mem_rd = '0; mem_wb_en = 0; mem_result = '0;
    flush = 0; cnt_clr = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.id_valid = 1; bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2;
    bus.id_use_rs1 = v.use1; bus.id_use_rs2 = v.use2; bus.ex_ready = 1;
    exs_valid = v.exs_v; exs_wb_en = v.exs_wb; exs_is_load = v.exs_ld;
    exs_rd = v.exs_rd; exs_result = v.exs_res;
    mem_valid = v.mem_v; mem_wb_en = v.mem_wb; mem_rd = v.mem_rd; mem_result = v.mem_res;
    rd0 = v.rf0; rd1 = v.rf1; flush = 0; cnt_clr = 0;
  endtask

  // Architectural value a reader of register idx should see: x0 is zero, otherwise
  // the newest in-flight producer whose data exists, falling back to the register file.
  function automatic logic [DW-1:0] arch_value(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
    logic          pv[2];
    logic [AW-1:0] pr[2];
    logic [DW-1:0] pd[2];
    if (idx == 0) return '0;
    pv[0] = exs_valid && exs_wb_en && !exs_is_load; pr[0] = exs_rd; pd[0] = exs_result;
    pv[1] = mem_valid && mem_wb_en;                 pr[1] = mem_rd; pd[1] = mem_result;
    for (int k = 0; k < 2; k++)
      if (pv[k] && pr[k] == idx) return pd[k];
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic load_in_ex;
    load_in_ex = exs_valid && exs_wb_en && exs_is_load && exs_rd != 0;
    return bus.id_valid && load_in_ex &&
           ((bus.id_use_rs1 && bus.id_rs1 == exs_rd) || (bus.id_use_rs2 && bus.id_rs2 == exs_rd));
  endfunction

  // Behavioural model state of the ID/EX register
  logic          m_valid, m_wb, m_ld;
  logic [DW-1:0] m_pc, m_op1, m_op2;
  logic [AW-1:0] m_rd;
  logic [CW-1:0] m_ctrl;
  int            m_cnt;

  task automatic runRandom(input int cycles);
    logic h, slot, accept;
    logic          n_valid, n_wb, n_ld;
    logic [DW-1:0] n_pc, n_op1, n_op2;
    logic [AW-1:0] n_rd;
    logic [CW-1:0] n_ctrl;
    int            n_cnt;
    m_valid = 0; m_wb = 0; m_ld = 0; m_pc = '0; m_op1 = '0; m_op2 = '0;
    m_rd = '0; m_ctrl = '0; m_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_pc = $urandom; bus.id_rs1 = AW'($urandom_range(0, 3)); bus.id_rs2 = AW'($urandom_range(0, 3));
      bus.id_use_rs1 = $urandom_range(0, 1); bus.id_use_rs2 = $urandom_range(0, 1);
      bus.id_rd = AW'($urandom_range(0, 31)); bus.id_wb_en = $urandom_range(0, 1);
      bus.id_is_load = $urandom_range(0, 1); bus.id_ctrl = CW'($urandom);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      rd0 = $urandom; rd1 = $urandom;
      exs_valid = $urandom_range(0, 1); exs_rd = AW'($urandom_range(0, 3));
      exs_wb_en = $urandom_range(0, 1); exs_is_load = $urandom_range(0, 1); exs_result = $urandom;
      mem_valid = $urandom_range(0, 1); mem_rd = AW'($urandom_range(0, 3));
      mem_wb_en = $urandom_range(0, 1); mem_result = $urandom;
      flush = ($urandom_range(0, 15) == 0); cnt_clr = ($urandom_range(0, 15) == 0);
      #1;
      h = model_hazard();
      slot = !m_valid || bus.ex_ready;
      checkOutput("rand_id_ready", bus.id_ready, slot && !h && !flush);
      checkOutput("rand_ra0", ra0, bus.id_rs1);
      checkOutput("rand_ra1", ra1, bus.id_rs2);
      accept = slot && bus.id_valid && !h && !flush;
      n_valid = flush ? 1'b0 : (slot ? (bus.id_valid && !h) : m_valid);
      n_pc = accept ? bus.id_pc : m_pc;
      n_op1 = accept ? arch_value(bus.id_rs1, rd0) : m_op1;
      n_op2 = accept ? arch_value(bus.id_rs2, rd1) : m_op2;
      n_rd = accept ? bus.id_rd : m_rd;
      n_wb = accept ? bus.id_wb_en : m_wb;
      n_ld = accept ? bus.id_is_load : m_ld;
      n_ctrl = accept ? bus.id_ctrl : m_ctrl;
      if (cnt_clr) n_cnt = 0;
      else if (h && slot && !flush) n_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      else n_cnt = m_cnt;
      @(posedge clk); #1;
      m_valid = n_valid; m_pc = n_pc; m_op1 = n_op1; m_op2 = n_op2; m_rd = n_rd;
      m_wb = n_wb; m_ld = n_ld; m_ctrl = n_ctrl; m_cnt = n_cnt;
      checkOutput("rand_ex_valid", bus.ex_valid, m_valid);
      checkOutput("rand_ex_pc", bus.ex_pc, m_pc);
      checkOutput("rand_ex_op1", bus.ex_op1, m_op1);
      checkOutput("rand_ex_op2", bus.ex_op2, m_op2);
      checkOutput("rand_ex_rd", bus.ex_rd, m_rd);
      checkOutput("rand_ex_wb_en", bus.ex_wb_en, m_wb);
      checkOutput("rand_ex_is_load", bus.ex_is_load, m_ld);
      checkOutput("rand_ex_ctrl", bus.ex_ctrl, m_ctrl);
      checkOutput("rand_stall_cnt", stall_cnt, 64'(m_cnt));
    end
  endtask

  initial begin
    logic [DW-1:0] held_pc;
    vecs[0] = '{1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA0, 32'hB0, 1, 1, 32'hA0, 32'hB0};
    vecs[1] = '{1, 2, 1, 1, 1, 1, 0, 1, 32'hC1, 1, 1, 2, 32'hD1, 32'hA1, 32'hB1, 1, 1, 32'hC1, 32'hD1};
    vecs[2] = '{2, 2, 1, 1, 1, 1, 0, 2, 32'hC2, 1, 1, 2, 32'hD2, 32'hA2, 32'hB2, 1, 1, 32'hC2, 32'hC2};
    vecs[3] = '{1, 2, 1, 1, 1, 0, 0, 1, 32'hC3, 1, 1, 1, 32'hD3, 32'hA3, 32'hB3, 1, 1, 32'hD3, 32'hB3};
    vecs[4] = '{1, 2, 0, 1, 1, 1, 1, 1, 32'hC4, 1, 1, 3, 32'hD4, 32'hA4, 32'hB4, 1, 1, 32'hA4, 32'hB4};
    vecs[5] = '{1, 2, 1, 1, 1, 1, 1, 2, 32'hC5, 0, 0, 0, 32'hD5, 32'hA5, 32'hB5, 0, 0, 32'h0, 32'h0};
    vecs[6] = '{1, 2, 1, 1, 0, 1, 0, 1, 32'hC6, 0, 1, 2, 32'hD6, 32'hA6, 32'hB6, 1, 1, 32'hA6, 32'hB6};
    vecs[7] = '{0, 0, 1, 1, 1, 1, 0, 0, 32'hC7, 1, 1, 0, 32'hD7, 32'hA7, 32'hB7, 1, 1, 32'h0, 32'h0};

    clearInputs();
    rstn = 0;
    #12;
    checkOutput("reset_ex_valid", bus.ex_valid, 0);
    checkOutput("reset_ex_op1", bus.ex_op1, 0);
    checkOutput("reset_ex_pc", bus.ex_pc, 0);
    checkOutput("reset_stall_cnt", stall_cnt, 0);
    @(negedge clk); rstn = 1;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_id_ready", i), bus.id_ready, vecs[i].exp_ready);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_ex_valid", i), bus.ex_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_ex_op1", i), bus.ex_op1, vecs[i].exp_op1);
        checkOutput($sformatf("vec%0d_ex_op2", i), bus.ex_op2, vecs[i].exp_op2);
      end
    end

    $display("[TB] EX over MEM priority");
    @(negedge clk); clearInputs();
    bus.id_valid = 1; bus.id_rs1 = 5; bus.id_use_rs1 = 1; rd0 = 32'h99;
    exs_valid = 1; exs_rd = 5; exs_wb_en = 1; exs_result = 32'h11;
    mem_valid = 1; mem_rd = 5; mem_wb_en = 1; mem_result = 32'h22;
    @(posedge clk); #1;
    checkOutput("fwd_ex_valid", bus.ex_valid, 1);
    checkOutput("fwd_ex_op1", bus.ex_op1, 32'h11);

    $display("[TB] load-use bubble");
    @(negedge clk); clearInputs(); cnt_clr = 1;
    @(negedge clk); clearInputs();
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_rs2 = 3; bus.id_use_rs2 = 1; rd1 = 32'h55;
    exs_valid = 1; exs_rd = 3; exs_wb_en = 1; exs_is_load = 1;
    #1;
    checkOutput("lu_id_ready", bus.id_ready, 0);
    @(posedge clk); #1;
    checkOutput("lu_bubble", bus.ex_valid, 0);
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    @(negedge clk);
    exs_valid = 0; mem_valid = 1; mem_rd = 3; mem_wb_en = 1; mem_result = 32'hAB;
    #1;
    checkOutput("lu_id_ready_after", bus.id_ready, 1);
    @(posedge clk); #1;
    checkOutput("lu_ex_valid", bus.ex_valid, 1);
    checkOutput("lu_ex_op2", bus.ex_op2, 32'hAB);
    checkOutput("lu_stall_cnt_hold", stall_cnt, 1);

    $display("[TB] backpressure");
    held_pc = 32'h100;
    @(negedge clk);
    bus.ex_ready = 0; bus.id_pc = 32'h200; mem_result = 32'hCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp%0d_id_ready", i), bus.id_ready, 0);
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_ex_valid", i), bus.ex_valid, 1);
      checkOutput($sformatf("bp%0d_ex_pc", i), bus.ex_pc, held_pc);
      checkOutput($sformatf("bp%0d_ex_op2", i), bus.ex_op2, 32'hAB);
      @(negedge clk);
    end
    bus.ex_ready = 1;
    @(posedge clk); #1;
    checkOutput("bp_release_pc", bus.ex_pc, 32'h200);
    checkOutput("bp_release_op2", bus.ex_op2, 32'hCD);

    $display("[TB] flush");
    @(negedge clk); clearInputs();
    bus.id_valid = 1; bus.id_pc = 32'h300; flush = 1;
    #1;
    checkOutput("flush_id_ready", bus.id_ready, 0);
    @(posedge clk); #1;
    checkOutput("flush_ex_valid", bus.ex_valid, 0);

    $display("[TB] reset mid-stream");
    @(negedge clk); clearInputs();
    bus.id_valid = 1; bus.id_rs1 = 7; bus.id_use_rs1 = 1; rd0 = 32'h1234;
    @(posedge clk); #1;
    checkOutput("mid_pre_valid", bus.ex_valid, 1);
    checkOutput("mid_pre_op1", bus.ex_op1, 32'h1234);
    checkOutput("mid_pre_cnt", stall_cnt, 1);
    #2 rstn = 0;
    #1;
    checkOutput("mid_rst_valid", bus.ex_valid, 0);
    checkOutput("mid_rst_op1", bus.ex_op1, 0);
    checkOutput("mid_rst_cnt", stall_cnt, 0);
    @(negedge clk); clearInputs(); rstn = 1;

    $display("[TB] randomized run");
    runRandom(600);

    $display("[TB] x0 never forwarded");
    @(negedge clk); clearInputs();
    bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_use_rs2 = 1; rd0 = 32'hFFFF; rd1 = 32'hFFFF;
    exs_valid = 1; exs_wb_en = 1; exs_result = 32'hFFFF;
    mem_valid = 1; mem_wb_en = 1; mem_result = 32'hFFFF;
    @(posedge clk); #1;
    checkOutput("x0_ex_op1", bus.ex_op1, 0);
    checkOutput("x0_ex_op2", bus.ex_op2, 0);

    $display("[TB] stall counter saturation");
    @(negedge clk); clearInputs(); cnt_clr = 1;
    @(negedge clk); clearInputs();
    bus.id_valid = 1; bus.id_rs1 = 4; bus.id_use_rs1 = 1;
    exs_valid = 1; exs_rd = 4; exs_wb_en = 1; exs_is_load = 1;
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat_cnt_fffe", stall_cnt, 16'hFFFE);
    @(posedge clk); #1;
    checkOutput("sat_cnt_ffff", stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat_cnt_hold", stall_cnt, 16'hFFFF);
    @(negedge clk); cnt_clr = 1;
    @(posedge clk); #1;
    checkOutput("sat_cnt_clr", stall_cnt, 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
